// File: rtl/vc_mem_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_req_gen
//  Description : Memory request generator / checker. A start pulse launches
//                a run. The run writes a seed-derived data pattern to
//                p_num_words consecutive words, then reads the words back.
//                Each response is checked in order against the index it
//                should carry, and each failing response increments
//                err_count.
//  Ports       : clk, reset (async, active-low)
//                start, seed          - run launch and data pattern base
//                memreq_*             - val/rdy request channel, 78-bit msg
//                memresp_*            - val/rdy response channel, 48-bit msg
//                busy, done, pass     - run status
//                err_count            - saturating response mismatch count
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_mem_req_gen #(
    parameter logic [31:0] p_base_addr       = 32'h0000_1000,
    parameter int          p_num_words       = 16,
    parameter int          p_max_outstanding = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic [77:0] memreq_msg,
    input  logic        memresp_val,
    output logic        memresp_rdy,
    input  logic [47:0] memresp_msg,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count
);

    localparam logic [8:0] c_NUM_WORDS = 9'(p_num_words);
    localparam logic [8:0] c_LAST_IDX  = 9'(p_num_words - 1);
    localparam logic [2:0] c_MAX_OUT   = 3'(p_max_outstanding);
    localparam logic [3:0] c_TYPE_RD   = 4'd0;
    localparam logic [3:0] c_TYPE_WR   = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WDRAIN = 3'd2,
        S_READ   = 3'd3,
        S_RDRAIN = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d;      // next word to request
    logic [2:0]  out_q, out_d;      // requests in flight
    logic [8:0]  exp_q, exp_d;      // index the next response must carry
    logic [31:0] seed_q, seed_d;
    logic [7:0]  err_q, err_d;

    logic        w_issue_phase;
    logic        w_write_phase;
    logic        w_in_run;
    logic        w_req_val;
    logic        w_req_fire;
    logic        w_resp_fire;
    logic        w_resp_bad;
    logic [3:0]  w_resp_type;
    logic [7:0]  w_resp_opq;
    logic [31:0] w_resp_data;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_data;
    logic        w_unused;

    assign w_issue_phase = (state_q == S_WRITE) || (state_q == S_READ);
    assign w_write_phase = (state_q == S_WRITE) || (state_q == S_WDRAIN);
    assign w_in_run      = (state_q == S_WRITE) || (state_q == S_WDRAIN) ||
                           (state_q == S_READ)  || (state_q == S_RDRAIN);

    assign w_req_val  = w_issue_phase && (idx_q < c_NUM_WORDS) && (out_q < c_MAX_OUT);
    assign w_req_fire = w_req_val && memreq_rdy;

    // Responses are only consumed while something is in flight during a run;
    // anything else (idle, done, stale traffic) is dropped unchecked.
    assign w_resp_fire = memresp_val && memresp_rdy && w_in_run && (out_q != 3'd0);

    assign w_resp_type = memresp_msg[47:44];
    assign w_resp_opq  = memresp_msg[43:36];
    assign w_resp_data = memresp_msg[31:0];
    assign w_unused    = ^memresp_msg[35:32];

    always_comb begin
        w_resp_bad = 1'b0;
        if (w_write_phase) begin
            w_resp_bad = (w_resp_type != c_TYPE_WR) || (w_resp_opq != exp_q[7:0]);
        end else begin
            w_resp_bad = (w_resp_type != c_TYPE_RD) || (w_resp_opq != exp_q[7:0]) ||
                         (w_resp_data != (seed_q + {23'd0, exp_q}));
        end
    end

    // The message is a pure function of idx_q/state_q/seed_q, none of which
    // move without a transfer, so it holds steady under backpressure.
    assign w_req_addr = p_base_addr + {21'd0, idx_q, 2'b00};
    assign w_req_data = (state_q == S_WRITE) ? (seed_q + {23'd0, idx_q}) : 32'd0;
    assign memreq_msg = {(state_q == S_WRITE) ? c_TYPE_WR : c_TYPE_RD,
                         idx_q[7:0], w_req_addr, 2'b00, w_req_data};
    assign memreq_val = w_req_val;

    assign memresp_rdy = 1'b1;
    assign busy        = w_in_run;
    assign done        = (state_q == S_DONE);
    assign pass        = (state_q == S_DONE) && (err_q == 8'd0);
    assign err_count   = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_d   = out_q;
        exp_d   = exp_q;
        seed_d  = seed_q;
        err_d   = err_q;

        // Simultaneous issue and retire cancel out.
        case ({w_req_fire, w_resp_fire})
            2'b10:   out_d = out_q + 3'd1;
            2'b01:   out_d = out_q - 3'd1;
            default: out_d = out_q;
        endcase

        if (w_req_fire) begin
            idx_d = idx_q + 9'd1;
        end

        if (w_resp_fire) begin
            exp_d = exp_q + 9'd1;
            if (w_resp_bad && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WRITE;
                    seed_d  = seed;
                    idx_d   = 9'd0;
                    out_d   = 3'd0;
                    exp_d   = 9'd0;
                    err_d   = 8'd0;
                end
            end
            S_WRITE: begin
                if (w_req_fire && (idx_q == c_LAST_IDX)) begin
                    state_d = S_WDRAIN;
                end
            end
            S_WDRAIN: begin
                if (out_q == 3'd0) begin
                    state_d = S_READ;
                    idx_d   = 9'd0;
                    exp_d   = 9'd0;
                end
            end
            S_READ: begin
                if (w_req_fire && (idx_q == c_LAST_IDX)) begin
                    state_d = S_RDRAIN;
                end
            end
            S_RDRAIN: begin
                if (out_q == 3'd0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 9'd0;
            out_q   <= 3'd0;
            exp_q   <= 9'd0;
            seed_q  <= 32'd0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            exp_q   <= exp_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_mem_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_mem_req_gen
//  Description : Self-checking bench for vc_mem_req_gen. A reference model
//                queues the request stream and run result each run must
//                produce; a monitor compares DUT transfers against them.
//                A queued test memory answers requests with a configurable
//                latency, optional backpressure and planned corruption.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_mem_req_gen;

    localparam int          N    = 4;
    localparam int          MAXO = 2;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = 32'd0;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [77:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [47:0] memresp_msg;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    vc_mem_req_gen #(
        .p_base_addr       (BASE),
        .p_num_words       (N),
        .p_max_outstanding (MAXO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seed        (seed),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count)
    );

    typedef struct packed {
        logic [7:0] err;
        logic       ok;
    } res_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [77:0] exp_req[$];
    res_t        exp_res[$];
    int          fire_cyc[$];
    logic [47:0] rq_msg[$];
    int          rq_due[$];
    logic [31:0] mem [logic [31:0]];

    int          lat      = 1;
    int          rdy_mode = 0;
    int          rdy_pct  = 100;
    logic [N-1:0] corr_w  = '0;
    logic [N-1:0] corr_r  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ------------------------------------------------------------------
    // Test memory: in-order queue, each response due lat cycles after its
    // request was accepted. Writes land in mem, reads return mem.
    // ------------------------------------------------------------------
    initial begin : responder
        logic        rf, qf;
        logic [77:0] m;
        logic [47:0] r;
        logic [31:0] d;
        int          i;
        memresp_val = 1'b0;
        memresp_msg = '0;
        memreq_rdy  = 1'b1;
        forever begin
            @(negedge clk);
            rf = memresp_val && memresp_rdy;
            qf = memreq_val && memreq_rdy;
            m  = memreq_msg;
            @(posedge clk);
            #1;
            if (rf && rq_msg.size() > 0) begin
                rq_msg.delete(0);
                rq_due.delete(0);
            end
            if (qf) begin
                i = int'(m[73:66]);
                if (m[77:74] == 4'd1) begin
                    mem[m[65:34]] = m[31:0];
                    r = {4'd1, m[73:66], 4'd0, 32'd0};
                    if (i < N && corr_w[i]) r[36] = ~r[36];
                end else begin
                    d = mem.exists(m[65:34]) ? mem[m[65:34]] : 32'd0;
                    r = {4'd0, m[73:66], 4'd0, d};
                    if (i < N && corr_r[i]) r[0] = ~r[0];
                end
                rq_msg.push_back(r);
                rq_due.push_back(cyc + lat - 1);
            end
            if (rq_msg.size() > 0 && rq_due[0] <= cyc) begin
                memresp_val = 1'b1;
                memresp_msg = rq_msg[0];
            end else begin
                memresp_val = 1'b0;
                memresp_msg = '0;
            end
            case (rdy_mode)
                0:       memreq_rdy = 1'b1;
                1:       memreq_rdy = cyc[0];
                default: memreq_rdy = ($urandom_range(99) < rdy_pct);
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor: checks every request transfer against the scoreboard, the
    // in-flight cap, stall stability, and the result when done rises.
    // ------------------------------------------------------------------
    initial begin : monitor
        logic        prev_stall;
        logic [77:0] prev_msg;
        logic        prev_done;
        int          outs;
        res_t        r;
        prev_stall = 1'b0;
        prev_msg   = '0;
        prev_done  = 1'b0;
        outs       = 0;
        forever begin
            @(negedge clk);
            chk("resp_rdy_high", memresp_rdy, 1);
            if (reset !== 1'b1) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                outs       = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_val_held", memreq_val, 1);
                    chk("stall_msg_held", memreq_msg, prev_msg);
                end
                if (memreq_val === 1'b1) begin
                    chk("req_within_cap", (outs < MAXO), 1);
                    chk("req_while_busy", busy, 1);
                end
                if (memreq_val === 1'b1 && memreq_rdy === 1'b1) begin
                    fire_cyc.push_back(cyc);
                    if (exp_req.size() == 0)
                        fail_note("unexpected_req", $sformatf("got msg %0h, required no request", memreq_msg));
                    else
                        chk("req_msg", memreq_msg, exp_req.pop_front());
                    outs++;
                end
                if (memresp_val === 1'b1 && memresp_rdy === 1'b1 && outs > 0) outs--;
                prev_stall = (memreq_val === 1'b1) && (memreq_rdy !== 1'b1);
                prev_msg   = memreq_msg;
                if (done === 1'b1 && !prev_done) begin
                    if (exp_res.size() == 0) begin
                        fail_note("unexpected_done", "got done=1, required no completion");
                    end else begin
                        r = exp_res.pop_front();
                        chk("done_err_count", err_count, r.err);
                        chk("done_pass", pass, r.ok);
                        chk("done_not_busy", busy, 0);
                    end
                end
                prev_done = (done === 1'b1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: the full request stream and result of one run.
    // ------------------------------------------------------------------
    task automatic pulse_start(input logic [31:0] s);
        @(negedge clk);
        #2;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        seed  = $urandom;
    endtask

    task automatic issue_run(input logic [31:0] s, input logic [N-1:0] cw, input logic [N-1:0] cr);
        int   ne;
        res_t r;
        for (int i = 0; i < N; i++)
            exp_req.push_back({4'd1, 8'(i), BASE + 32'(4 * i), 2'b00, s + 32'(i)});
        for (int i = 0; i < N; i++)
            exp_req.push_back({4'd0, 8'(i), BASE + 32'(4 * i), 2'b00, 32'd0});
        ne    = $countones(cw) + $countones(cr);
        r.err = 8'((ne > 255) ? 255 : ne);
        r.ok  = (ne == 0);
        exp_res.push_back(r);
        corr_w = cw;
        corr_r = cr;
        pulse_start(s);
    endtask

    task automatic recover();
        @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        exp_req.delete();
        exp_res.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            fail_note(name, $sformatf("got done=0 after %0d cycles, required done=1", budget));
            recover();
        end else begin
            @(negedge clk);
            #2;
            chk({name, "_reqs_left"}, exp_req.size(), 0);
            chk({name, "_results_left"}, exp_res.size(), 0);
        end
    endtask

    initial begin : main
        int   k;
        logic found;

        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_req_val", memreq_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_resp_rdy", memresp_rdy, 1);
        chk("rst_err_count", err_count, 0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("idle_busy", busy, 0);
        chk("idle_req_val", memreq_val, 0);

        // Basic run
        lat = 1; rdy_mode = 0;
        issue_run(32'h0000_0100, '0, '0);
        wait_done("basic", 300);

        // Backpressure: ready toggles every cycle
        rdy_mode = 1;
        issue_run($urandom, '0, '0);
        wait_done("backpressure", 400);

        // Corrupted read data on index 2
        rdy_mode = 0;
        issue_run($urandom, '0, 4'b0100);
        wait_done("corrupt_read2", 300);

        // Same-cycle issue/retire at one in flight, plus start during WRITE
        lat = 1; rdy_mode = 0;
        fire_cyc.delete();
        issue_run($urandom, '0, '0);
        pulse_start($urandom);
        wait_done("same_cycle", 300);
        chk("same_cycle_fires", fire_cyc.size(), 2 * N);
        if (fire_cyc.size() == 2 * N) begin
            chk("write_back_to_back", fire_cyc[N-1] - fire_cyc[0], N - 1);
            chk("read_back_to_back", fire_cyc[2*N-1] - fire_cyc[N], N - 1);
        end

        // Randomized runs
        for (int t = 0; t < 6; t++) begin
            lat      = int'($urandom_range(3, 1));
            rdy_mode = 2;
            rdy_pct  = int'($urandom_range(100, 30));
            issue_run($urandom,
                      N'($urandom) & N'($urandom),
                      N'($urandom) & N'($urandom));
            wait_done($sformatf("random_%0d", t), 600);
        end

        // Reset during READ while index 2 is being presented
        lat = 3; rdy_mode = 0; rdy_pct = 100;
        issue_run($urandom, '0, '0);
        k = 0;
        found = 1'b0;
        while (!found && k < 200) begin
            @(negedge clk);
            k++;
            if (memreq_val === 1'b1 && memreq_msg[77:74] == 4'd0 && memreq_msg[73:66] == 8'd2)
                found = 1'b1;
        end
        chk("midrun_reached_read2", found, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrun_rst_req_val", memreq_val, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_resp_rdy", memresp_rdy, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_req.delete();
        exp_res.delete();
        rq_msg.push_back({4'd0, 8'd5, 4'd0, 32'hBAD0_BAD0});
        rq_due.push_back(cyc);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stale_no_req", memreq_val, 0);
            chk("stale_idle", busy, 0);
            chk("stale_err_count", err_count, 0);
        end
        chk("stale_drained", rq_msg.size(), 0);
        lat = 1;
        issue_run($urandom, '0, '0);
        wait_done("after_reset", 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish, required finish within 300000 time units");
        $fatal(1, "bench stopped by watchdog");
    end

endmodule
`default_nettype wire
